// File: rtl/tbb1143_tone_gen.sv
// Three-channel square-wave tone generator behind an async 4-bit host bus; bus writes land SYNC_STAGES+1 CLK edges after WR rises.
// No backpressure: writes are fire-and-forget; optional LFSR noise source under `TBB1143_NOISE_EN.
module tbb1143_tone_gen #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic D0,
  input  logic D1,
  input  logic D2,
  input  logic D3,
  input  logic A0,
  input  logic WR,
  output logic SOUT0,
  output logic SOUT1,
  output logic SOUT2
);

  logic [3:0]             d_in;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] a0_sync;
  logic [3:0]             d_sync [SYNC_STAGES];
  logic                   wr_prev;
  logic                   wr_stb;
  logic                   wr_a0;
  logic [3:0]             wr_dat;

  logic [3:0]  ptr;
  logic [11:0] period [3];
  logic [2:0]  mask;
  logic [11:0] cnt [3];
  logic [2:0]  tog;
  logic [2:0]  wrap;
  logic [2:0]  sout;

  assign d_in = {D3, D2, D1, D0};

  // Bus pins are asynchronous to CLK; every bit gets its own synchroniser chain.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_sync <= '0;
      a0_sync <= '0;
      wr_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        d_sync[i] <= '0;
      end
    end else begin
      wr_sync <= {wr_sync[SYNC_STAGES-2:0], WR};
      a0_sync <= {a0_sync[SYNC_STAGES-2:0], A0};
      d_sync[0] <= d_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        d_sync[i] <= d_sync[i-1];
      end
      wr_prev <= wr_sync[SYNC_STAGES-1];
    end
  end

  assign wr_stb = wr_sync[SYNC_STAGES-1] & ~wr_prev;
  assign wr_a0  = a0_sync[SYNC_STAGES-1];
  assign wr_dat = d_sync[SYNC_STAGES-1];

`ifdef TBB1143_NOISE_EN
  logic [2:0]  noise_sel;
  logic [14:0] lfsr;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr  <= '0;
      mask <= '0;
      for (int n = 0; n < 3; n++) begin
        period[n] <= '0;
      end
`ifdef TBB1143_NOISE_EN
      noise_sel <= '0;
`endif
    end else if (wr_stb) begin
      if (!wr_a0) begin
        ptr <= wr_dat;
      end else begin
        case (ptr)
          4'd0:    period[0][3:0]  <= wr_dat;
          4'd1:    period[0][7:4]  <= wr_dat;
          4'd2:    period[0][11:8] <= wr_dat;
          4'd3:    period[1][3:0]  <= wr_dat;
          4'd4:    period[1][7:4]  <= wr_dat;
          4'd5:    period[1][11:8] <= wr_dat;
          4'd6:    period[2][3:0]  <= wr_dat;
          4'd7:    period[2][7:4]  <= wr_dat;
          4'd8:    period[2][11:8] <= wr_dat;
          4'd9:    mask            <= wr_dat[2:0];
`ifdef TBB1143_NOISE_EN
          4'd10:   noise_sel       <= wr_dat[2:0];
`endif
          default: ;
        endcase
        ptr <= ptr + 4'd1;
      end
    end
  end

  // ">=" rather than "==" so a period lowered below the running count wraps at once.
  always_comb begin
    wrap = '0;
    for (int n = 0; n < 3; n++) begin
      wrap[n] = mask[n] && (cnt[n] >= period[n]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tog <= '0;
      for (int n = 0; n < 3; n++) begin
        cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (!mask[n]) begin
          cnt[n] <= '0;
          tog[n] <= 1'b0;
        end else if (wrap[n]) begin
          cnt[n] <= '0;
          tog[n] <= ~tog[n];
        end else begin
          cnt[n] <= cnt[n] + 12'd1;
        end
      end
    end
  end

`ifdef TBB1143_NOISE_EN
  // Noise clock is channel 2's wrap, independent of which channels select noise.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lfsr <= 15'h0001;
    end else if (wrap[2]) begin
      lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    end
  end

  always_comb begin
    sout = tog;
    for (int n = 0; n < 3; n++) begin
      if (mask[n] && noise_sel[n]) begin
        sout[n] = lfsr[0];
      end
    end
  end
`else
  assign sout = tog;
`endif

  assign SOUT0 = sout[0];
  assign SOUT1 = sout[1];
  assign SOUT2 = sout[2];

endmodule

// File: tb/tb_tbb1143_tone_gen.sv
// Scoreboarded bench: a time-based reference model predicts SOUT every cycle; a monitor compares at negedge+1.
module tb_tbb1143_tone_gen;

  localparam int SS = 2;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic D0 = 1'b0, D1 = 1'b0, D2 = 1'b0, D3 = 1'b0;
  logic A0 = 1'b0;
  logic WR = 1'b0;
  logic SOUT0, SOUT1, SOUT2;

  always #5 CLK = ~CLK;

  tbb1143_tone_gen #(.SYNC_STAGES(SS)) dut (
    .CLK(CLK), .RST(RST),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3),
    .A0(A0), .WR(WR),
    .SOUT0(SOUT0), .SOUT1(SOUT1), .SOUT2(SOUT2)
  );

  typedef struct {
    int         eff;
    logic       a0;
    logic [3:0] d;
  } wr_t;

  wr_t        pend[$];
  logic [2:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  // Reference model: register file plus, per channel, the edge index at which its count was last zero.
  logic [3:0]  regs [16];
  logic [3:0]  ptr_m;
  logic [2:0]  out_m;
  int          base_m [3];
  logic [14:0] lfsr_m;

  function automatic int period_of(int n);
    logic [11:0] p;
    p = {regs[3*n+2], regs[3*n+1], regs[3*n]};
    return int'(p);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) regs[i] = 4'h0;
    ptr_m  = 4'h0;
    out_m  = 3'b000;
    lfsr_m = 15'h0001;
    for (int n = 0; n < 3; n++) base_m[n] = cyc + 1;
    pend.delete();
  endtask

  task automatic model_step(input int k);
    logic [2:0] en;
    wr_t        w;
    en = regs[9][2:0];
    for (int n = 0; n < 3; n++) begin
      if (en[n]) begin
        if (k - base_m[n] >= period_of(n)) begin
          out_m[n]  = ~out_m[n];
          base_m[n] = k + 1;
          if (n == 2) lfsr_m = 15'(((lfsr_m << 1) | (((lfsr_m >> 14) ^ (lfsr_m >> 13)) & 15'd1)));
        end
      end else begin
        out_m[n]  = 1'b0;
        base_m[n] = k + 1;
      end
    end
    while (pend.size() > 0 && pend[0].eff == k) begin
      w = pend.pop_front();
      if (!w.a0) begin
        ptr_m = w.d;
      end else begin
        regs[ptr_m] = w.d;
        ptr_m = ptr_m + 4'd1;
      end
    end
  endtask

  function automatic logic [2:0] expected();
    logic [2:0] e;
    e = out_m;
`ifdef TBB1143_NOISE_EN
    for (int n = 0; n < 3; n++) begin
      if (regs[9][n] && regs[10][n]) e[n] = lfsr_m[0];
    end
`endif
    return e;
  endfunction

  initial model_clear();

  always @(posedge CLK) begin
    if (RST) begin
      cyc = cyc + 1;
      model_step(cyc);
    end
  end

  always @(negedge CLK) begin
    if (!RST) model_clear();
    exp_q.push_back(expected());
  end

  // Monitor: decoupled from stimulus, pops one prediction per cycle.
  always @(negedge CLK) begin
    logic [2:0] e;
    logic [2:0] got;
    #1;
    got = {SOUT2, SOUT1, SOUT0};
    checks = checks + 1;
    if (exp_q.size() == 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_empty cycle %0d: got %b, no prediction queued", cyc, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors = errors + 1;
        $display("FAIL sout cycle %0d t=%0t: got %b required %b", cyc, $time, got, e);
      end
    end
  end

  task automatic bus_write(input logic a, input logic [3:0] d);
    @(negedge CLK);
    #2;
    A0 = a;
    {D3, D2, D1, D0} = d;
    WR = 1'b1;
    pend.push_back('{cyc + SS + 1, a, d});
    repeat (SS + 2) @(negedge CLK);
    #2;
    WR = 1'b0;
    repeat (SS + 2) @(negedge CLK);
  endtask

  logic [3:0] all_seq [10];

  initial begin
    // Reset held with WR toggling: nothing may get through.
    repeat (5) begin
      @(negedge CLK);
      #2;
      WR = ~WR;
      A0 = 1'($urandom_range(0, 1));
      {D3, D2, D1, D0} = 4'($urandom_range(0, 15));
    end
    @(negedge CLK);
    #2;
    WR = 1'b0;
    @(negedge CLK);
    #2;
    RST = 1'b1;
    repeat (100) @(negedge CLK);

    // Channel 0 at period 3.
    bus_write(1'b0, 4'd0);
    bus_write(1'b1, 4'd3);
    bus_write(1'b1, 4'd0);
    bus_write(1'b1, 4'd0);
    bus_write(1'b0, 4'd9);
    bus_write(1'b1, 4'd1);
    repeat (40) @(negedge CLK);

    // All channels: periods 0, 0x00F, 0xFFF, mask 7.
    all_seq = '{4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h7};
    bus_write(1'b0, 4'd0);
    for (int i = 0; i < 10; i++) bus_write(1'b1, all_seq[i]);
    repeat (8300) @(negedge CLK);

    // Live update: ch0 at 0x0FF, then drop nibble 1 to 0 while the count is high.
    bus_write(1'b0, 4'd0);
    bus_write(1'b1, 4'hF);
    bus_write(1'b1, 4'hF);
    bus_write(1'b1, 4'h0);
    repeat (180) @(negedge CLK);
    bus_write(1'b0, 4'd1);
    bus_write(1'b1, 4'h0);
    repeat (60) @(negedge CLK);

    // Pointer wrap 15 -> 0, then disable everything, then re-enable.
    bus_write(1'b0, 4'd15);
    bus_write(1'b1, 4'h4);
    bus_write(1'b1, 4'h5);
    repeat (30) @(negedge CLK);
    bus_write(1'b0, 4'd9);
    bus_write(1'b1, 4'h0);
    repeat (10) @(negedge CLK);
    bus_write(1'b0, 4'd9);
    bus_write(1'b1, 4'h7);
    repeat (50) @(negedge CLK);

    // Reset mid-stream while a write is still in the synchroniser.
    @(negedge CLK);
    #2;
    A0 = 1'b0;
    {D3, D2, D1, D0} = 4'd3;
    WR = 1'b1;
    pend.push_back('{cyc + SS + 1, 1'b0, 4'd3});
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    #2;
    WR = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    RST = 1'b1;
    repeat (5) @(negedge CLK);

    // Randomised writes, periodically re-enabling all channels.
    for (int i = 0; i < 60; i++) begin
      if (i % 12 == 11) begin
        bus_write(1'b0, 4'd9);
        bus_write(1'b1, 4'h7);
      end else begin
        bus_write(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge CLK);
    end
    repeat (200) @(negedge CLK);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbb1143_tone_gen.md
Name: tbb1143_tone_gen

Overview:
- Three-channel programmable square-wave sound generator (TBB1143 core).
- Host writes a 4-bit data bus through a two-port register interface: A0 selects the address or data port, WR is the strobe.
- Each channel divides CLK by a programmable 12-bit period and drives a 1-bit audio output (SOUT0..2).
- Sits behind the chip pad ring; the bus pins are asynchronous to CLK.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising WR, A0 and D[3:0] into the CLK domain (minimum 2).

Ports:
- CLK  input  1  system clock; all state is in this single domain.
- RST  input  1  reset, asynchronous, active-low.
- D0..D3  input  1 each  host data nibble; D0 is the LSB.
- A0  input  1  port select: 0 = address port, 1 = data port.
- WR  input  1  write strobe; a write is performed on its rising edge.
- SOUT0, SOUT1, SOUT2  output  1 each  channel 0/1/2 square-wave outputs.

Behaviour:
- Reset (RST=0, async) clears all state to 0:
  - address pointer, all period registers, enable mask, counters, output toggles, synchroniser flops;
  - SOUT0..2 = 0 while RST is low and immediately after release.
- Bus capture:
  - WR, A0 and D each pass through SYNC_STAGES flops.
  - One extra flop on synced WR detects its rising edge.
  - On a detected edge, the synced A0/D are used for the write.
  - A write takes effect SYNC_STAGES+1 CLK edges after the WR rising edge.
  - WR must stay high, and A0/D stable, for at least SYNC_STAGES+1 CLK cycles.
  - A WR falling edge does nothing.
- A0=0 write: address pointer := D.
- A0=1 write: register[pointer] := D, then pointer := pointer+1, wrapping 15 -> 0.
- Register map:
  - 0/1/2 = channel 0 period bits [3:0]/[7:4]/[11:8];
  - 3..5 = channel 1 period, same nibble order;
  - 6..8 = channel 2 period, same nibble order;
  - 9 = enable mask, bit n enables channel n, bit 3 ignored;
  - 10 = noise select (optional feature);
  - 11..15 = writes ignored, but the pointer still increments.
- Channel n, enabled:
  - the 12-bit counter increments every CLK;
  - when counter >= period_n, the counter returns to 0 and SOUTn toggles;
  - output frequency = fCLK / (2 x (period_n + 1));
  - period 0 toggles SOUTn every cycle.
- The >= compare means a period lowered below the current count wraps on the next cycle, never after 4096 cycles.
- Period nibble updates take effect immediately; there is no double-buffering.
- Channel disabled: counter held at 0 and SOUTn forced to 0 synchronously on the next CLK.
- Re-enabling: the counter starts from 0 and the first toggle (to 1) comes after period+1 cycles.
- Channels are fully independent; simultaneous toggles are allowed.
- Reset mid-operation aborts any pending synchronised write.

Optional Feature:
- Macro TBB1143_NOISE_EN.
- Defined:
  - adds a 15-bit LFSR, polynomial x^15+x^14+1, reset seed 15'h0001, shifting left;
  - new bit 0 = bit14 XOR bit13;
  - the LFSR steps once per channel 2 counter wrap, whether or not channel 2 is noise-selected;
  - register 10 bits [2:0] select noise per channel;
  - an enabled, noise-selected channel drives SOUTn = LFSR bit 0 instead of its toggle flop;
  - a disabled channel still outputs 0.
- Not defined: no LFSR; register 10 behaves like 11..15 (ignored); outputs are pure square waves.

Test Plan:
- Reset: hold RST=0 for 5 cycles with WR toggling -> SOUT0..2 = 0 throughout. Release, no writes -> outputs stay 0 for 100 cycles.
- Channel 0 at period 3:
  - writes: A0=0 D=0; A0=1 D=3, D=0, D=0 (auto-increment fills addresses 0..2); A0=0 D=9; A0=1 D=1;
  - required response: SOUT0 toggles every 4 CLK cycles (period 8); SOUT1 = SOUT2 = 0.
- All three channels:
  - periods ch0 = 0, ch1 = 0x00F, ch2 = 0xFFF, mask 7;
  - required response: SOUT0 toggles every cycle, SOUT1 every 16 cycles, SOUT2 every 4096 cycles.
- Live update: ch0 running at period 0x0FF with counter near 200; write nibble 1 to 0 (period becomes 0x00F) -> wrap and toggle on the next CLK, then every 16 cycles.
- Address wrap and disable:
  - pointer at 15, data write -> pointer becomes 0 (next data write lands in register 0);
  - write mask 0 -> all SOUT = 0 by the cycle after the write takes effect.
- Write latency: with SYNC_STAGES=2, register update visible exactly 3 CLK edges after the WR rise. Async reset asserted mid-stream -> all outputs 0 within the same cycle.
